mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 mult_div SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter MULT_CYCLES, default 5, SHALL set the mult/multu latency in cycles.
REQ-003 Parameter DIV_CYCLES, default 10, SHALL set the div/divu latency in cycles.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 MDUIn1  input  32  rs operand, forwarded value from the EX stage.
REQ-007 MDUIn2  input  32  rt operand, forwarded value from the EX stage.
REQ-008 MDUOp  input  4  operation: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 mfhi, 1000 mflo; other values act as none.
REQ-009 Req  input  1  exception/interrupt flush of the EX instruction; high means ignore the write-class op this cycle.
REQ-010 Busy  output  1  a multiply or divide is in flight.
REQ-011 MDUStall  output  1  equals Busy OR (MDUOp is mult/multu/div/divu).
REQ-012 MDUOut  output  32  HI for mfhi, LO for mflo, else 32'h0; combinational.

Function
REQ-013 A start SHALL occur at a rising edge where MDUOp is mult/multu/div/divu, Busy=0, Req=0 and reset=0.
REQ-014 On a start the block SHALL latch both operands and the op, then load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 Busy SHALL be 1 from the start edge for exactly N cycles, with N the loaded latency.
REQ-016 The counter SHALL decrement by one each edge while Busy=1.
REQ-017 At the edge where the counter goes 1->0, HI/LO SHALL be written and Busy SHALL fall.
- Result visible on MDUOut N cycles after the start edge.
REQ-018 mult/multu SHALL compute the signed/unsigned 64-bit product, with HI=[63:32] and LO=[31:0].
REQ-019 div/divu SHALL set LO=quotient truncated toward zero and HI=remainder, whose sign follows the dividend for div.
REQ-020 div 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 A divisor of 0 SHALL still run DIV_CYCLES and SHALL leave HI and LO unchanged at completion.
REQ-022 mthi/mtlo SHALL write MDUIn1 into HI/LO at the edge when Busy=0 and Req=0.
REQ-023 Any mult/div/mthi/mtlo presented while Busy=1 SHALL be ignored.
- The controller guarantees this via MDUStall, so the op is re-presented after Busy falls.
REQ-024 Req=1 SHALL suppress a start or an mthi/mtlo in the same cycle.
REQ-025 Req=1 SHALL NOT cancel an operation already in flight; that operation completes normally.
REQ-026 mfhi/mflo SHALL read the committed HI/LO with no bypass; while Busy=1 the old value is returned and the controller stalls.
REQ-027 Operand changes on MDUIn1/MDUIn2 after the start edge SHALL NOT affect the result.

Reset
REQ-028 reset=1 at an edge SHALL clear HI, LO, the counter, the latched operands and Busy to 0.
REQ-029 reset SHALL take priority over start, completion, mthi and mtlo in the same edge.
REQ-030 reset mid-operation SHALL discard the pending result.
REQ-031 After reset, Busy=0, MDUStall is determined by MDUOp alone, and MDUOut=0.

Structure
REQ-032 Package mdu_pkg SHALL hold the MDUOp encodings and the MULT_CYCLES/DIV_CYCLES defaults.
REQ-033 Arithmetic SHALL use behavioural operators in one module; no sub-module is required.
- The result is computed at the start edge into a 64-bit pending register and committed at completion.

Verification
REQ-034 mult 0xFFFFFFFF x 0x00000002 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy high exactly 5 cycles.
REQ-035 multu 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-036 div -7 by 2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-037 divu 7 by 0 -> HI and LO keep their prior value 0x12345678/0x9ABCDEF0 (set by mthi/mtlo), Busy high 10 cycles.
REQ-038 mult started, then mtlo 0x55 and mfhi while Busy=1, then Req=1 with a second mult -> mtlo ignored, mfhi returns the old HI, the first mult completes, the second never starts.
REQ-039 reset asserted 3 cycles into a div -> Busy=0, HI=LO=0 next cycle, and no later write occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings, default
// latencies and small op-classification helpers.
package mdu_pkg;

   localparam int MULT_CYCLES_DEFAULT = 5;
   localparam int DIV_CYCLES_DEFAULT  = 10;

   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;
   localparam logic [3:0] OP_MFHI  = 4'b0111;
   localparam logic [3:0] OP_MFLO  = 4'b1000;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   function automatic logic is_md_op(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// when the op starts, held in a pending register, and committed when the counter expires.
module mult_div
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDUIn1,
   input  logic [31:0] MDUIn2,
   input  logic [3:0]  MDUOp,
   input  logic        Req,
   output logic        Busy,
   output logic        MDUStall,
   output logic [31:0] MDUOut
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [31:0]      hi_reg;
   logic [31:0]      lo_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic [3:0]       op_reg;
   logic [31:0]      in1_reg;
   logic [31:0]      in2_reg;
   hilo_t            pend_reg;
   hilo_t            pend_next;

   logic md_op;
   logic start;
   logic idle_write;
   logic finish;
   logic commit;

   assign md_op      = is_md_op(MDUOp);
   assign start      = md_op && !busy_reg && !Req;
   assign idle_write = !busy_reg && !Req;
   assign finish     = busy_reg && (cnt_reg == CNT_ONE);
   // A divide by zero runs its full latency but leaves HI/LO untouched.
   assign commit     = !(is_div_op(op_reg) && (in2_reg == '0));

   // The dividend is latched for completeness; only the divisor gates the commit.
   logic unused_in1;
   assign unused_in1 = ^in1_reg;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   assign prod_s = {{32{MDUIn1[31]}}, MDUIn1} * {{32{MDUIn2[31]}}, MDUIn2};
   assign prod_u = {32'h0, MDUIn1} * {32'h0, MDUIn2};

   // Divisor forced to 1 when zero so the operators stay defined; the result is discarded.
   logic [31:0] divu_den;
   logic [31:0] mag_num;
   logic [31:0] mag_den;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq_mag;
   logic [31:0] sr_mag;
   logic [31:0] sq;
   logic [31:0] sr;

   assign divu_den = (MDUIn2 == '0) ? 32'd1 : MDUIn2;
   assign mag_num  = MDUIn1[31] ? (32'd0 - MDUIn1) : MDUIn1;
   assign mag_den  = MDUIn2[31] ? (32'd0 - MDUIn2) : divu_den;
   assign uq       = MDUIn1 / divu_den;
   assign ur       = MDUIn1 % divu_den;
   assign sq_mag   = mag_num / mag_den;
   assign sr_mag   = mag_num % mag_den;
   // Magnitude divide then re-sign: truncates toward zero, remainder follows the dividend.
   assign sq       = (MDUIn1[31] ^ MDUIn2[31]) ? (32'd0 - sq_mag) : sq_mag;
   assign sr       = MDUIn1[31] ? (32'd0 - sr_mag) : sr_mag;

   always_comb begin
      pend_next = '0;
      case (MDUOp)
         OP_MULT:  pend_next = prod_s;
         OP_MULTU: pend_next = prod_u;
         OP_DIV:   pend_next = '{hi: sr, lo: sq};
         OP_DIVU:  pend_next = '{hi: ur, lo: uq};
         default:  pend_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         op_reg   <= OP_NONE;
         in1_reg  <= '0;
         in2_reg  <= '0;
         pend_reg <= '0;
      end else if (start) begin
         op_reg   <= MDUOp;
         in1_reg  <= MDUIn1;
         in2_reg  <= MDUIn2;
         pend_reg <= pend_next;
         cnt_reg  <= is_div_op(MDUOp) ? DIV_LOAD : MULT_LOAD;
         busy_reg <= 1'b1;
      end else if (busy_reg) begin
         cnt_reg <= cnt_reg - CNT_ONE;
         if (finish) begin
            busy_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (finish) begin
         if (commit) begin
            hi_reg <= pend_reg.hi;
            lo_reg <= pend_reg.lo;
         end
      end else if (idle_write) begin
         if (MDUOp == OP_MTHI) begin
            hi_reg <= MDUIn1;
         end
         if (MDUOp == OP_MTLO) begin
            lo_reg <= MDUIn1;
         end
      end
   end

   always_comb begin
      MDUOut = '0;
      case (MDUOp)
         OP_MFHI: MDUOut = hi_reg;
         OP_MFLO: MDUOut = lo_reg;
         default: MDUOut = '0;
      endcase
   end

   assign Busy     = busy_reg;
   assign MDUStall = busy_reg || md_op;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: a vector table of arithmetic cases plus
// hand-written sequences for busy-time writes, Req suppression and reset.
module tb_mult_div;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] MDUIn1;
   logic [31:0] MDUIn2;
   logic [3:0]  MDUOp;
   logic        Req;
   logic        Busy;
   logic        MDUStall;
   logic [31:0] MDUOut;

   always #5 clk = ~clk;

   mult_div dut (
      .clk      (clk),
      .reset    (reset),
      .MDUIn1   (MDUIn1),
      .MDUIn2   (MDUIn2),
      .MDUOp    (MDUOp),
      .Req      (Req),
      .Busy     (Busy),
      .MDUStall (MDUStall),
      .MDUOut   (MDUOut)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cycles;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];
   res_t sb [$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic write_hi(input logic [31:0] v);
      MDUOp  = OP_MTHI;
      MDUIn1 = v;
      @(negedge clk);
      MDUOp  = OP_NONE;
   endtask

   task automatic write_lo(input logic [31:0] v);
      MDUOp  = OP_MTLO;
      MDUIn1 = v;
      @(negedge clk);
      MDUOp  = OP_NONE;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      MDUOp = OP_MFHI;
      #1 hi = MDUOut;
      MDUOp = OP_MFLO;
      #1 lo = MDUOut;
      MDUOp = OP_NONE;
   endtask

   // Counts negedges with Busy high; bounded so a stuck Busy cannot hang the run.
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (Busy && cyc < 64) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] hi, lo;
      res_t        exp;
      int          cyc;

      vecs[0]  = '{"mult_neg1x2",   OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hDEAD0000, 32'h0000BEEF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{"multu_max_x2",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'hDEAD0000, 32'h0000BEEF, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{"div_m7_by_2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{"divu_by_zero",  OP_DIVU,  32'h00000007, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 10};
      vecs[4]  = '{"div_overflow",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h11111111, 32'h22222222, 32'h00000000, 32'h80000000, 10};
      vecs[5]  = '{"divu_100_by_7", OP_DIVU,  32'd100,      32'd7,        32'h0,        32'h0,        32'h00000002, 32'h0000000E, 10};
      vecs[6]  = '{"mult_maxpos",   OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h3FFFFFFF, 32'h00000001, 5};
      vecs[7]  = '{"div_7_by_m2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
      vecs[8]  = '{"multu_max_sq",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFE, 32'h00000001, 5};
      vecs[9]  = '{"mult_m3x5",     OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
      vecs[10] = '{"div_by_zero",   OP_DIV,   32'h00000005, 32'h00000000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0002, 10};

      reset  = 1'b1;
      Req    = 1'b0;
      MDUOp  = OP_NONE;
      MDUIn1 = '0;
      MDUIn2 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("reset_busy", 32'(Busy), 32'd0);
      check("reset_stall_none", 32'(MDUStall), 32'd0);
      MDUOp = OP_MULT;
      #1 check("reset_stall_mult", 32'(MDUStall), 32'd1);
      MDUOp = OP_NONE;
      read_hilo(hi, lo);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      $display("reset: busy=%0b hi=%h lo=%h", Busy, hi, lo);

      for (int i = 0; i < NVEC; i++) begin
         write_hi(vecs[i].pre_hi);
         write_lo(vecs[i].pre_lo);
         MDUOp  = vecs[i].op;
         MDUIn1 = vecs[i].a;
         MDUIn2 = vecs[i].b;
         sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
         @(negedge clk);
         MDUOp  = OP_NONE;
         MDUIn1 = $urandom;
         MDUIn2 = $urandom;
         wait_idle(cyc);
         check({vecs[i].name, "_busy_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
         read_hilo(hi, lo);
         exp = sb.pop_front();
         check({vecs[i].name, "_hi"}, hi, exp.hi);
         check({vecs[i].name, "_lo"}, lo, exp.lo);
         $display("vec %0d %s: a=%h b=%h busy=%0d hi=%h lo=%h", i, vecs[i].name,
                  vecs[i].a, vecs[i].b, cyc, hi, lo);
      end

      // Writes and a second start presented while busy must be ignored.
      write_hi(32'hAAAA0000);
      write_lo(32'h00001111);
      MDUOp  = OP_MULT;
      MDUIn1 = 32'd3;
      MDUIn2 = 32'd4;
      sb.push_back('{32'h0, 32'h0000000C});
      @(negedge clk);
      check("busy_seq_busy", 32'(Busy), 32'd1);
      MDUOp  = OP_MTLO;
      MDUIn1 = 32'h55;
      @(negedge clk);
      MDUOp = OP_MFHI;
      #1 check("busy_seq_mfhi_old", MDUOut, 32'hAAAA0000);
      check("busy_seq_stall", 32'(MDUStall), 32'd1);
      MDUOp  = OP_MULT;
      MDUIn1 = 32'd9;
      MDUIn2 = 32'd9;
      Req    = 1'b1;
      @(negedge clk);
      Req   = 1'b0;
      MDUOp = OP_NONE;
      wait_idle(cyc);
      check("busy_seq_cycles", 32'(cyc + 2), 32'd5);
      read_hilo(hi, lo);
      exp = sb.pop_front();
      check("busy_seq_hi", hi, exp.hi);
      check("busy_seq_lo", lo, exp.lo);
      @(negedge clk);
      check("busy_seq_no_restart", 32'(Busy), 32'd0);
      $display("busy seq: cycles=%0d hi=%h lo=%h", cyc + 2, hi, lo);

      // Req suppresses a start and an mthi while idle.
      MDUOp  = OP_MULT;
      MDUIn1 = 32'd9;
      MDUIn2 = 32'd9;
      Req    = 1'b1;
      @(negedge clk);
      check("req_no_start", 32'(Busy), 32'd0);
      MDUOp  = OP_MTHI;
      MDUIn1 = 32'h77;
      @(negedge clk);
      Req   = 1'b0;
      MDUOp = OP_NONE;
      read_hilo(hi, lo);
      check("req_no_mthi", hi, 32'h0);
      check("req_lo_kept", lo, 32'h0000000C);
      $display("req seq: busy=%0b hi=%h lo=%h", Busy, hi, lo);

      // Reset three cycles into a divide discards the pending result.
      write_hi(32'h00001111);
      write_lo(32'h00002222);
      MDUOp  = OP_DIV;
      MDUIn1 = 32'd100;
      MDUIn2 = 32'd7;
      @(negedge clk);
      MDUOp = OP_NONE;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", 32'(Busy), 32'd0);
      read_hilo(hi, lo);
      check("midreset_hi", hi, 32'h0);
      check("midreset_lo", lo, 32'h0);
      repeat (12) @(negedge clk);
      check("midreset_busy_later", 32'(Busy), 32'd0);
      read_hilo(hi, lo);
      check("midreset_hi_later", hi, 32'h0);
      check("midreset_lo_later", lo, 32'h0);
      $display("mid-reset seq: busy=%0b hi=%h lo=%h", Busy, hi, lo);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
